pkc_key_streamer: RTL and testbench

//  Upstream feeder for PKC_TOP. Reads stored key matrices from a synchronous key memory and replays them row/column-wise, one per cycle.

---
 rtl/pkc_key_streamer_pkg.sv | 72 +++++++
 rtl/pkc_key_streamer_if.sv | 40 ++++
 rtl/pkc_key_streamer_section_counter.sv | 43 ++++
 rtl/pkc_key_streamer.sv | 177 +++++++++++++++++
 tb/tb_pkc_key_streamer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pkc_key_streamer_pkg.sv
// Shared key-store geometry: code sizes, memory map, FSM encoding and section helpers.
package pkc_key_streamer_pkg;

    localparam int unsigned Q     = 3;
    localparam int unsigned T     = 1;
    localparam int unsigned N_MSG = Q * Q;
    localparam int unsigned N_PAR = 2 * T * Q;
    localparam int unsigned K_LEN = N_MSG + N_PAR;
    localparam int unsigned DEPTH = 3 * N_MSG + 3 * K_LEN + N_PAR;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(K_LEN + 1);

    localparam int unsigned BASE_G  = 0;
    localparam int unsigned BASE_S  = N_MSG;
    localparam int unsigned BASE_P  = 2 * N_MSG;
    localparam int unsigned BASE_HR = 2 * N_MSG + K_LEN;
    localparam int unsigned BASE_HC = 2 * N_MSG + K_LEN + N_PAR;
    localparam int unsigned BASE_SI = 2 * N_MSG + 2 * K_LEN + N_PAR;
    localparam int unsigned BASE_PI = 3 * N_MSG + 2 * K_LEN + N_PAR;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KG_G,
        ST_KG_S,
        ST_KG_P,
        ST_DC_HR,
        ST_DC_HC,
        ST_DC_SI,
        ST_DC_PI
    } state_e;

    function automatic logic [AW-1:0] sec_base(input state_e s);
        case (s)
            ST_KG_G:  return AW'(BASE_G);
            ST_KG_S:  return AW'(BASE_S);
            ST_KG_P:  return AW'(BASE_P);
            ST_DC_HR: return AW'(BASE_HR);
            ST_DC_HC: return AW'(BASE_HC);
            ST_DC_SI: return AW'(BASE_SI);
            ST_DC_PI: return AW'(BASE_PI);
            default:  return AW'(0);
        endcase
    endfunction

    // Element count of section idx within a keygen (job_dc=0) or decrypt (job_dc=1) job.
    function automatic logic [CW-1:0] sec_len(input logic job_dc, input logic [1:0] idx);
        if (!job_dc) begin
            case (idx)
                2'd0, 2'd1: return CW'(N_MSG);
                default:    return CW'(K_LEN);
            endcase
        end else begin
            case (idx)
                2'd0:    return CW'(N_PAR);
                2'd2:    return CW'(N_MSG);
                default: return CW'(K_LEN);
            endcase
        end
    endfunction

    function automatic state_e next_section(input state_e s);
        case (s)
            ST_KG_G:  return ST_KG_S;
            ST_KG_S:  return ST_KG_P;
            ST_DC_HR: return ST_DC_HC;
            ST_DC_HC: return ST_DC_SI;
            ST_DC_SI: return ST_DC_PI;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pkc_key_streamer_if.sv
// Job control, key-memory port and matrix buses between the streamer and its environment.
interface pkc_key_streamer_if;

    logic                                     load_keygen;
    logic                                     load_decrypt;
    logic                                     mem_rd_en;
    logic [pkc_key_streamer_pkg::AW-1:0]      mem_addr;
    logic [pkc_key_streamer_pkg::K_LEN-1:0]   mem_rd_data;
    logic                                     start;
    logic [pkc_key_streamer_pkg::K_LEN-1:0]   generator;
    logic                                     generator_ready;
    logic [pkc_key_streamer_pkg::N_MSG-1:0]   S;
    logic                                     S_ready;
    logic [pkc_key_streamer_pkg::K_LEN-1:0]   P;
    logic                                     P_ready;
    logic [pkc_key_streamer_pkg::K_LEN-1:0]   parity_check_row;
    logic [pkc_key_streamer_pkg::N_PAR-1:0]   parity_check_col;
    logic                                     parity_ready;
    logic [pkc_key_streamer_pkg::N_MSG-1:0]   S_inv;
    logic                                     S_inv_ready;
    logic [pkc_key_streamer_pkg::K_LEN-1:0]   P_inv;
    logic                                     P_inv_ready;
    logic                                     busy;
    logic                                     done;

    modport master (
        input  load_keygen, load_decrypt, mem_rd_data,
        output mem_rd_en, mem_addr, start, generator, generator_ready, S, S_ready, P, P_ready,
               parity_check_row, parity_check_col, parity_ready, S_inv, S_inv_ready,
               P_inv, P_inv_ready, busy, done
    );

    modport slave (
        output load_keygen, load_decrypt, mem_rd_data,
        input  mem_rd_en, mem_addr, start, generator, generator_ready, S, S_ready, P, P_ready,
               parity_check_row, parity_check_col, parity_ready, S_inv, S_inv_ready,
               P_inv, P_inv_ready, busy, done
    );

endinterface

// File: rtl/pkc_key_streamer_section_counter.sv
// Element counter within a section; owns the section lengths of each job type.
module pkc_section_counter
    import pkc_key_streamer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_job_dc,
    input  logic i_advance,
    output logic o_terminal_c,
    output logic o_job_last_c
);

    logic [CW-1:0] r_count;
    logic [1:0]    r_section;
    logic          r_job_dc;
    logic [CW-1:0] w_len;
    logic [1:0]    w_last_idx;

    assign w_len        = sec_len(r_job_dc, r_section);
    assign w_last_idx   = r_job_dc ? 2'd3 : 2'd2;
    assign o_terminal_c = i_advance && (r_count == (w_len - CW'(1)));
    assign o_job_last_c = o_terminal_c && (r_section == w_last_idx);

    // Count wraps to 0 at every section boundary; section index steps on terminal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_section <= '0;
            r_job_dc  <= 1'b0;
        end else if (i_start) begin
            r_count   <= '0;
            r_section <= '0;
            r_job_dc  <= i_job_dc;
        end else if (o_terminal_c) begin
            r_count   <= '0;
            r_section <= r_section + 2'd1;
        end else if (i_advance) begin
            r_count   <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/pkc_key_streamer.sv
// Replays key matrices from a synchronous key memory onto the PKC_TOP buses, one element per cycle.
module pkc_key_streamer
    import pkc_key_streamer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    pkc_key_streamer_if.master bus
);

    state_e          r_state, w_state_nx;
    logic            r_rd_en, w_rd_en_nx;
    logic [AW-1:0]   r_addr, w_addr_nx;
    logic            w_kg_go, w_dc_go;
    logic            w_term_c, w_job_last_c;

    logic            r_vld1, r_last1, r_last2;
    state_e          r_sec1;
    logic            r_busy, r_done, r_start;
    logic [K_LEN-1:0] r_gen, r_p, r_hrow, r_pi;
    logic [N_MSG-1:0] r_s, r_si;
    logic [N_PAR-1:0] r_hcol;
    logic            r_gen_rdy, r_s_rdy, r_p_rdy, r_h_rdy, r_si_rdy, r_pi_rdy;

    pkc_section_counter u_counter (
        .clk          (clk),
        .reset        (reset),
        .i_start      (w_kg_go || w_dc_go),
        .i_job_dc     (w_dc_go),
        .i_advance    (r_state != ST_IDLE),
        .o_terminal_c (w_term_c),
        .o_job_last_c (w_job_last_c)
    );

    // State always names the section of the address currently on mem_addr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rd_en <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_rd_en <= w_rd_en_nx;
            r_addr  <= w_addr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_rd_en_nx = 1'b0;
        w_addr_nx  = r_addr;
        w_kg_go    = 1'b0;
        w_dc_go    = 1'b0;
        if (r_state == ST_IDLE) begin
            if (!r_busy && bus.load_keygen) begin
                w_kg_go    = 1'b1;
                w_state_nx = ST_KG_G;
            end else if (!r_busy && bus.load_decrypt) begin
                w_dc_go    = 1'b1;
                w_state_nx = ST_DC_HR;
            end
            if (w_state_nx != ST_IDLE) begin
                w_rd_en_nx = 1'b1;
                w_addr_nx  = sec_base(w_state_nx);
            end
        end else if (w_term_c) begin
            w_state_nx = next_section(r_state);
            w_rd_en_nx = !w_job_last_c;
            if (!w_job_last_c) begin
                w_addr_nx = sec_base(w_state_nx);
            end
        end else begin
            w_rd_en_nx = 1'b1;
            w_addr_nx  = r_addr + AW'(1);
        end
    end

    // Read data arrives one cycle after the strobe; route it by the section tag delayed alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld1    <= 1'b0;
            r_last1   <= 1'b0;
            r_last2   <= 1'b0;
            r_sec1    <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_start   <= 1'b0;
            r_gen     <= '0;
            r_s       <= '0;
            r_p       <= '0;
            r_hrow    <= '0;
            r_hcol    <= '0;
            r_si      <= '0;
            r_pi      <= '0;
            r_gen_rdy <= 1'b0;
            r_s_rdy   <= 1'b0;
            r_p_rdy   <= 1'b0;
            r_h_rdy   <= 1'b0;
            r_si_rdy  <= 1'b0;
            r_pi_rdy  <= 1'b0;
        end else begin
            r_vld1  <= r_rd_en;
            r_sec1  <= r_state;
            r_last1 <= w_job_last_c;
            r_last2 <= r_vld1 && r_last1;
            r_done  <= r_last2;
            if (w_kg_go || w_dc_go) begin
                r_busy <= 1'b1;
            end else if (r_last2) begin
                r_busy <= 1'b0;
            end
            if (w_kg_go) begin
                r_gen_rdy <= 1'b0;
                r_s_rdy   <= 1'b0;
                r_p_rdy   <= 1'b0;
            end
            if (w_dc_go) begin
                r_h_rdy  <= 1'b0;
                r_si_rdy <= 1'b0;
                r_pi_rdy <= 1'b0;
            end
            if (r_vld1) begin
                case (r_sec1)
                    ST_KG_G: begin
                        r_gen     <= bus.mem_rd_data;
                        r_gen_rdy <= 1'b1;
                        r_start   <= 1'b1;
                    end
                    ST_KG_S: begin
                        r_s     <= bus.mem_rd_data[N_MSG-1:0];
                        r_s_rdy <= 1'b1;
                    end
                    ST_KG_P: begin
                        r_p     <= bus.mem_rd_data;
                        r_p_rdy <= 1'b1;
                    end
                    ST_DC_HR: begin
                        r_hrow  <= bus.mem_rd_data;
                        r_h_rdy <= 1'b1;
                    end
                    ST_DC_HC: begin
                        r_hcol  <= bus.mem_rd_data[N_PAR-1:0];
                        r_h_rdy <= 1'b1;
                    end
                    ST_DC_SI: begin
                        r_si     <= bus.mem_rd_data[N_MSG-1:0];
                        r_si_rdy <= 1'b1;
                    end
                    ST_DC_PI: begin
                        r_pi     <= bus.mem_rd_data;
                        r_pi_rdy <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_rd_en        = r_rd_en;
    assign bus.mem_addr         = r_addr;
    assign bus.start            = r_start;
    assign bus.generator        = r_gen;
    assign bus.generator_ready  = r_gen_rdy;
    assign bus.S                = r_s;
    assign bus.S_ready          = r_s_rdy;
    assign bus.P                = r_p;
    assign bus.P_ready          = r_p_rdy;
    assign bus.parity_check_row = r_hrow;
    assign bus.parity_check_col = r_hcol;
    assign bus.parity_ready     = r_h_rdy;
    assign bus.S_inv            = r_si;
    assign bus.S_inv_ready      = r_si_rdy;
    assign bus.P_inv            = r_pi;
    assign bus.P_inv_ready      = r_pi_rdy;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;

endmodule

// File: tb/tb_pkc_key_streamer.sv
// Bench for pkc_key_streamer: random key store, expectations derived from the memory map and job timing.
module tb_pkc_key_streamer;
    import pkc_key_streamer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pkc_key_streamer_if bus ();

    pkc_key_streamer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [K_LEN-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[int'(bus.mem_addr)];
    end

    int checks = 0;
    int errors = 0;
    bit start_seen = 1'b0;
    // Section order: G, S, P, HR, HC, SI, PI
    int bases  [7] = '{0, 9, 18, 33, 39, 54, 63};
    int widths [7] = '{15, 9, 15, 15, 6, 9, 15};

    function automatic int sec_of_addr(input int a);
        for (int i = 6; i >= 0; i--) if (a >= bases[i]) return i;
        return 0;
    endfunction

    function automatic logic [14:0] get_bus(input int s);
        case (s)
            0: return 15'(bus.generator);
            1: return 15'(bus.S);
            2: return 15'(bus.P);
            3: return 15'(bus.parity_check_row);
            4: return 15'(bus.parity_check_col);
            5: return 15'(bus.S_inv);
            default: return 15'(bus.P_inv);
        endcase
    endfunction

    function automatic logic get_ready(input int s);
        case (s)
            0: return bus.generator_ready;
            1: return bus.S_ready;
            2: return bus.P_ready;
            3, 4: return bus.parity_ready;
            5: return bus.S_inv_ready;
            default: return bus.P_inv_ready;
        endcase
    endfunction

    function automatic logic [127:0] all_outs();
        return 128'({bus.mem_rd_en, bus.mem_addr, bus.start, bus.generator, bus.generator_ready,
                     bus.S, bus.S_ready, bus.P, bus.P_ready, bus.parity_check_row,
                     bus.parity_check_col, bus.parity_ready, bus.S_inv, bus.S_inv_ready,
                     bus.P_inv, bus.P_inv_ready, bus.busy, bus.done});
    endfunction

    task automatic randomize_mem();
        for (int a = 0; a < int'(DEPTH); a++) mem[a] = 15'($urandom);
    endtask

    // Issue a load at the next edge (cycle 0) and check every cycle through the done pulse.
    task automatic run_job(input bit dc, input bit both, input int inject_at);
        int len, b0, first, last, e, s;
        logic [14:0] exp_v, mask;
        logic exp_b;
        len   = dc ? 45 : 33;
        b0    = dc ? 33 : 0;
        first = dc ? 3 : 0;
        last  = dc ? 6 : 2;
        bus.load_keygen  = !dc || both;
        bus.load_decrypt = dc || both;
        for (int c = 0; c <= len + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_b = (c < len);
            checks++;
            if (bus.mem_rd_en !== exp_b) begin
                errors++; $display("FAIL rd_en c=%0d got=%b exp=%b", c, bus.mem_rd_en, exp_b);
            end
            if (exp_b) begin
                checks++;
                if (bus.mem_addr !== AW'(b0 + c)) begin
                    errors++; $display("FAIL addr c=%0d got=%0d exp=%0d", c, bus.mem_addr, b0 + c);
                end
            end
            if (c >= 2 && c <= len + 1) begin
                e = c - 2;
                s = sec_of_addr(b0 + e);
                mask  = 15'((32'd1 << widths[s]) - 1);
                exp_v = mem[b0 + e] & mask;
                checks++;
                if (get_bus(s) !== exp_v) begin
                    errors++; $display("FAIL bus%0d c=%0d got=%h exp=%h", s, c, get_bus(s), exp_v);
                end
            end
            for (int k = first; k <= last; k++) begin
                if (k == 4) continue;
                exp_b = (c >= 2 + bases[k] - b0);
                checks++;
                if (get_ready(k) !== exp_b) begin
                    errors++; $display("FAIL ready%0d c=%0d got=%b exp=%b", k, c, get_ready(k), exp_b);
                end
            end
            exp_b = start_seen || (!dc && c >= 2);
            checks++;
            if (bus.start !== exp_b) begin
                errors++; $display("FAIL start c=%0d got=%b exp=%b", c, bus.start, exp_b);
            end
            checks++;
            if (bus.busy !== (c <= len + 1)) begin
                errors++; $display("FAIL busy c=%0d got=%b exp=%b", c, bus.busy, c <= len + 1);
            end
            checks++;
            if (bus.done !== (c == len + 2)) begin
                errors++; $display("FAIL done c=%0d got=%b exp=%b", c, bus.done, c == len + 2);
            end
            if (inject_at >= 0) begin
                checks++;
                if (bus.parity_ready !== 1'b0) begin
                    errors++; $display("FAIL parity_ready_busy c=%0d got=%b exp=0", c, bus.parity_ready);
                end
            end
            bus.load_keygen  = 1'b0;
            bus.load_decrypt = (c + 1 == inject_at);
        end
        if (!dc) start_seen = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.load_keygen  = 1'b0;
        bus.load_decrypt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL reset_outs got=%h exp=0", all_outs());
        end
        reset = 1'b0;
        start_seen = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL idle_outs got=%h exp=0", all_outs());
        end
    endtask

    task automatic test_keygen();
        randomize_mem();
        run_job(1'b0, 1'b0, -1);
    endtask

    task automatic test_decrypt();
        run_job(1'b1, 1'b0, -1);
        checks++;
        if (bus.generator !== mem[8]) begin
            errors++; $display("FAIL hold_gen got=%h exp=%h", bus.generator, mem[8]);
        end
        checks++;
        if (bus.parity_check_col !== mem[53][5:0]) begin
            errors++; $display("FAIL hold_hcol got=%h exp=%h", bus.parity_check_col, mem[53][5:0]);
        end
    endtask

    task automatic test_back_to_back();
        randomize_mem();
        run_job(1'b0, 1'b0, -1);
        run_job(1'b1, 1'b0, -1);
    endtask

    task automatic test_simultaneous();
        run_job(1'b0, 1'b1, -1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_rd_en !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL simul_idle c=%0d rd_en=%b busy=%b exp=0", c, bus.mem_rd_en, bus.busy);
            end
        end
    endtask

    task automatic test_load_while_busy();
        test_reset();
        run_job(1'b0, 1'b0, 10);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.parity_ready !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            errors++; $display("FAIL dropped_dc parity=%b rd_en=%b exp=0", bus.parity_ready, bus.mem_rd_en);
        end
    endtask

    task automatic test_mid_reset();
        bus.load_keygen = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.load_keygen = 1'b0;
        end
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== AW'(14)) begin
            errors++; $display("FAIL mid_job rd_en=%b addr=%0d exp=1/14", bus.mem_rd_en, bus.mem_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL async_reset got=%h exp=0", all_outs());
        end
        @(negedge clk);
        reset = 1'b0;
        start_seen = 1'b0;
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL reset_hold got=%h exp=0", all_outs());
        end
        run_job(1'b0, 1'b0, -1);
    endtask

    task automatic test_width();
        for (int a = 9; a < 18; a++) mem[a] = 15'h7FFF;
        run_job(1'b0, 1'b0, -1);
        checks++;
        if (bus.S !== 9'h1FF) begin
            errors++; $display("FAIL s_width got=%h exp=1ff", bus.S);
        end
    endtask

    initial begin
        test_reset();
        test_keygen();
        test_decrypt();
        test_back_to_back();
        test_simultaneous();
        test_load_while_busy();
        test_mid_reset();
        test_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
